// File: rtl/adder_sum_accum.sv
// adder_sum_accum: frames successive prefix-adder sums into a wider running
// total and hands each frame result downstream on a registered valid/ready
// output. A frame closes after BEATS accepted sums or earlier on in_last.
module adder_sum_accum #(
  parameter int SUM_W = 7,
  parameter int ACC_W = 10,
  parameter int BEATS = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } outState_t;

  outState_t        r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_outAcc;
  logic [CNT_W-1:0] r_outCount;
  logic             r_outOvf;

  logic             w_accept;
  logic             w_transfer;
  logic             w_closing;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_ovfNext;

  // Input readiness depends only on output occupancy and downstream ready, so
  // a held result frees its slot on the same edge a new beat is taken.
  always_comb begin
    in_ready   = (r_state == EMPTY) || out_ready;
    w_accept   = in_valid && in_ready;
    w_transfer = (r_state == FULL) && out_ready;
    w_sum      = {1'b0, r_acc} + {{(ACC_W+1-SUM_W){1'b0}}, in_sum};
    w_ovfNext  = r_ovf | w_sum[ACC_W];
    w_cntNext  = r_cnt + 1'b1;
    w_closing  = w_accept && (in_last || (r_cnt == CNT_W'(BEATS-1)));
  end

  // Accumulate accepted beats, publish the result on a closing beat and track
  // output occupancy; reset drops any partial frame and any held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_outAcc   <= '0;
      r_outCount <= '0;
      r_outOvf   <= 1'b0;
    end else begin
      if (w_closing) begin
        r_outAcc   <= w_sum[ACC_W-1:0];
        r_outOvf   <= w_ovfNext;
        r_outCount <= w_cntNext;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_ovf      <= 1'b0;
      end else if (w_accept) begin
        r_acc <= w_sum[ACC_W-1:0];
        r_cnt <= w_cntNext;
        r_ovf <= w_ovfNext;
      end

      case (r_state)
        EMPTY: if (w_closing) r_state <= FULL;
        FULL:  if (w_transfer && !w_closing) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Every output field comes straight from a flop.
  always_comb begin
    out_valid = (r_state == FULL);
    out_acc   = r_outAcc;
    out_count = r_outCount;
    out_ovf   = r_outOvf;
  end

endmodule

// File: tb/tb_adder_sum_accum.sv
// tb_adder_sum_accum: directed and randomized stimulus for adder_sum_accum,
// checked against an integer frame model kept in the bench.
module tb_adder_sum_accum;

  localparam int SUM_W = 7;
  localparam int ACC_W = 10;
  localparam int BEATS = 16;
  localparam int CNT_W = 5;
  localparam int MODV  = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int nVec  = 0;
  int nFail = 0;

  // Reference model: the true (unbounded) frame sum and beat count, plus the
  // last published frame result.
  bit mValid;
  int mOutAcc;
  int mOutCnt;
  bit mOutOvf;
  int mSum;
  int mBeats;

  adder_sum_accum #(
    .SUM_W(SUM_W), .ACC_W(ACC_W), .BEATS(BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
    checkOutput({tag, ".out_acc"},   32'(out_acc),   32'(mOutAcc));
    checkOutput({tag, ".out_count"}, 32'(out_count), 32'(mOutCnt));
    checkOutput({tag, ".out_ovf"},   32'(out_ovf),   32'(mOutOvf));
  endtask

  task automatic clearModel();
    mValid  = 1'b0;
    mOutAcc = 0;
    mOutCnt = 0;
    mOutOvf = 1'b0;
    mSum    = 0;
    mBeats  = 0;
  endtask

  // Hold reset for n edges while offering a max-value beat that must be ignored.
  task automatic doReset(input int n);
    rst = 1'b1; in_valid = 1'b1; in_sum = 7'h7F; in_last = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    checkAll("reset");
    #1;
    checkOutput("resetInReady", 32'(in_ready), 32'd1);
  endtask

  // One clock of stimulus: check in_ready before the edge, outputs after it.
  task automatic applyStimulus(input bit v, input int s, input bit l, input bit r);
    bit accept, transfer, close;
    in_valid = v; in_sum = SUM_W'(s); in_last = l; out_ready = r;
    #1;
    checkOutput("inReady", 32'(in_ready), 32'(!mValid || r));
    accept   = v && (!mValid || r);
    transfer = mValid && r;
    @(posedge clk);
    #1;
    close = 1'b0;
    if (accept) begin
      mSum   += s;
      mBeats += 1;
      close  = l || (mBeats == BEATS);
    end
    if (close) begin
      mOutAcc = mSum % MODV;
      mOutOvf = (mSum >= MODV);
      mOutCnt = mBeats;
      mValid  = 1'b1;
      mSum    = 0;
      mBeats  = 0;
    end else if (transfer) begin
      mValid = 1'b0;
    end
    checkAll("step");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_last = 1'b0; out_ready = 1'b0;
    clearModel();
    @(posedge clk); #1;

    // Reset with a pending beat offered.
    doReset(2);

    // Full frame of max sums wraps and sets overflow.
    for (int i = 0; i < BEATS; i++) applyStimulus(1'b1, 127, 1'b0, 1'b1);
    checkOutput("fullAcc",   32'(out_acc),   32'd1008);
    checkOutput("fullCount", 32'(out_count), 32'd16);
    checkOutput("fullOvf",   32'(out_ovf),   32'd1);

    // Early close on in_last.
    applyStimulus(1'b1, 3,  1'b0, 1'b1);
    applyStimulus(1'b1, 5,  1'b0, 1'b1);
    applyStimulus(1'b1, 10, 1'b1, 1'b1);
    checkOutput("earlyAcc",   32'(out_acc),   32'd18);
    checkOutput("earlyCount", 32'(out_count), 32'd3);
    checkOutput("earlyOvf",   32'(out_ovf),   32'd0);

    // Back-pressure: held result stalls input, then transfer plus acceptance.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9, 1'b0, 1'b0);
    checkOutput("bpHeldAcc", 32'(out_acc), 32'd18);
    applyStimulus(1'b1, 9, 1'b0, 1'b1);
    checkOutput("bpReleased", 32'(out_valid), 32'd0);
    doReset(1);

    // Close after 15 ones plus 64, then an immediate one-beat frame with no bubble.
    for (int i = 0; i < BEATS-1; i++) applyStimulus(1'b1, 1, 1'b0, 1'b1);
    applyStimulus(1'b1, 64, 1'b0, 1'b1);
    checkOutput("simAcc",   32'(out_acc),   32'd79);
    checkOutput("simCount", 32'(out_count), 32'd16);
    applyStimulus(1'b1, 5, 1'b1, 1'b1);
    checkOutput("noBubbleValid", 32'(out_valid), 32'd1);
    checkOutput("noBubbleAcc",   32'(out_acc),   32'd5);

    // Reset mid-frame discards the partial total.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 100, 1'b0, 1'b1);
    doReset(1);
    applyStimulus(1'b1, 7, 1'b0, 1'b1);
    applyStimulus(1'b1, 7, 1'b1, 1'b1);
    checkOutput("midRstAcc",   32'(out_acc),   32'd14);
    checkOutput("midRstCount", 32'(out_count), 32'd2);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) doReset(1);
      else applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
                         $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
